wide_alu_sequencer: RTL and testbench

- Multi-cycle controller that runs LIMBS×BUS-bit arithmetic and logic operations on one narrow BUS-bit ALU, one limb per cycle, least-significant limb first.
- Arithmetic limbs are chained by feeding each limb's carry-out into the next limb's CNVZI[3].
- Sits between the execute-stage issue logic and the shared ALU instance, and owns the ALU's operand, function and flag-input buses while busy.
- Produces the wide result and whole-word CNVZ flags with a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/limb_mux.sv | 23 ++
 rtl/wide_alu_sequencer.sv | 149 ++++++++++++++
 tb/tb_wide_alu_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the narrow ALU and the wide-operation sequencer.
// Contents: ALUFUN encodings, wide-op encoding, sequencer FSM states and
// CNVZ flag bit positions.
package alu_pkg;

  // ALUFUN encodings, shared with ALUController.
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_ADC = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_SBC = 4'h3;
  localparam logic [3:0] ALU_AND = 4'h4;
  localparam logic [3:0] ALU_XOR = 4'h6;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } wide_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } seq_state_t;

  // Bit positions inside a {C,N,V,Z} flag nibble.
  localparam int unsigned C_BIT = 3;
  localparam int unsigned N_BIT = 2;
  localparam int unsigned V_BIT = 1;
  localparam int unsigned Z_BIT = 0;

endpackage

// File: rtl/limb_mux.sv
// Combinational limb selector: returns limb idx (BUS bits) of a LIMBS*BUS word.
// Ports:
//   word  in   LIMBS*BUS  source word, limb 0 in the least-significant bits
//   idx   in   IdxW       limb index, values >= LIMBS yield zero
//   limb  out  BUS        selected limb
module limb_mux #(
  parameter int unsigned BUS   = 4,
  parameter int unsigned LIMBS = 4,
  parameter int unsigned IdxW  = $clog2(LIMBS)
) (
  input  logic [BUS*LIMBS-1:0] word,
  input  logic [IdxW-1:0]      idx,
  output logic [BUS-1:0]       limb
);

  always_comb begin
    limb = '0;
    for (int unsigned i = 0; i < LIMBS; i++) begin
      if (idx == i[IdxW-1:0]) limb = word[i*BUS +: BUS];
    end
  end

endmodule

// File: rtl/wide_alu_sequencer.sv
// Runs LIMBS*BUS-bit add/sub/and/xor on a shared BUS-bit ALU, one limb per
// cycle, least-significant limb first, chaining carries through CNVZI[3].
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   start, op           request pulse (accepted only when idle), wide operation
//   a_wide, b_wide      operands, latched on an accepted start
//   busy, done          busy from accept through the done cycle; done is a pulse
//   result, cnvz        wide result and {C,N,V,Z}, held until the next accept
//   alu_a, alu_b        current operand limbs to the ALU
//   alu_fun             ALUFUN to the ALU
//   alu_cnvz_in         CNVZI to the ALU (only the carry bit is used)
//   alu_s, alu_cnvz_out limb result and flags from the ALU
module wide_alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned BUS   = 4,
  parameter int unsigned LIMBS = 4,
  localparam int unsigned W    = BUS * LIMBS,
  localparam int unsigned IdxW = $clog2(LIMBS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a_wide,
  input  logic [W-1:0]   b_wide,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result,
  output logic [3:0]     cnvz,
  output logic [BUS-1:0] alu_a,
  output logic [BUS-1:0] alu_b,
  output logic [3:0]     alu_fun,
  output logic [3:0]     alu_cnvz_in,
  input  logic [BUS-1:0] alu_s,
  input  logic [3:0]     alu_cnvz_out
);

  seq_state_t      state_q;
  wide_op_t        op_q;
  logic [IdxW-1:0] k_q;
  logic [W-1:0]    a_q, b_q, result_q;
  logic [3:0]      cnvz_q;
  logic            carry_q, zacc_q, busy_q, done_q;

  logic is_arith, first_limb, last_limb, z_next;

  assign is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign first_limb = (k_q == '0);
  assign last_limb  = (k_q == IdxW'(LIMBS - 1));
  assign z_next     = zacc_q & alu_cnvz_out[Z_BIT];

  limb_mux #(.BUS(BUS), .LIMBS(LIMBS), .IdxW(IdxW)) u_mux_a (
    .word (a_q),
    .idx  (k_q),
    .limb (alu_a)
  );

  limb_mux #(.BUS(BUS), .LIMBS(LIMBS), .IdxW(IdxW)) u_mux_b (
    .word (b_q),
    .idx  (k_q),
    .limb (alu_b)
  );

  // Function/carry-in are decoded from registered state only; outside RUN the
  // bus is parked on AND with no carry.
  always_comb begin
    alu_fun     = ALU_AND;
    alu_cnvz_in = '0;
    if (state_q == StRun) begin
      unique case (op_q)
        OP_ADD: begin
          alu_fun            = first_limb ? ALU_ADD : ALU_ADC;
          alu_cnvz_in[C_BIT] = first_limb ? 1'b0 : carry_q;
        end
        OP_SUB: begin
          alu_fun            = first_limb ? ALU_SUB : ALU_SBC;
          alu_cnvz_in[C_BIT] = first_limb ? 1'b0 : carry_q;
        end
        OP_AND:  alu_fun = ALU_AND;
        OP_XOR:  alu_fun = ALU_XOR;
        default: alu_fun = ALU_AND;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OP_ADD;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnvz_q   <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q     <= wide_op_t'(op);
            a_q      <= a_wide;
            b_q      <= b_wide;
            k_q      <= '0;
            zacc_q   <= 1'b1;
            carry_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          for (int unsigned i = 0; i < LIMBS; i++) begin
            if (k_q == i[IdxW-1:0]) result_q[i*BUS +: BUS] <= alu_s;
          end
          carry_q <= alu_cnvz_out[C_BIT];
          zacc_q  <= z_next;
          if (last_limb) begin
            if (is_arith) begin
              cnvz_q <= {alu_cnvz_out[C_BIT], alu_cnvz_out[N_BIT], alu_cnvz_out[V_BIT], z_next};
            end else begin
              // alu_s is the top limb here, so its MSB is result[W-1].
              cnvz_q <= {1'b0, alu_s[BUS-1], 1'b0, z_next};
            end
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cnvz   = cnvz_q;

endmodule

// File: tb/tb_wide_alu_sequencer.sv
// Self-checking bench for wide_alu_sequencer with a behavioural limb ALU and a
// whole-word arithmetic reference model.
module tb_wide_alu_sequencer;
  import alu_pkg::*;

  localparam int unsigned BUS   = 4;
  localparam int unsigned LIMBS = 4;
  localparam int unsigned W     = BUS * LIMBS;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     op = 2'd0;
  logic [W-1:0]   a_wide = '0, b_wide = '0;
  logic           busy, done;
  logic [W-1:0]   result;
  logic [3:0]     cnvz;
  logic [BUS-1:0] alu_a, alu_b, alu_s;
  logic [3:0]     alu_fun, alu_cnvz_in, alu_cnvz_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wide_alu_sequencer #(.BUS(BUS), .LIMBS(LIMBS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .a_wide       (a_wide),
    .b_wide       (b_wide),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .cnvz         (cnvz),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_fun      (alu_fun),
    .alu_cnvz_in  (alu_cnvz_in),
    .alu_s        (alu_s),
    .alu_cnvz_out (alu_cnvz_out)
  );

  // Behavioural narrow ALU.
  logic [BUS:0]   alu_sum;
  logic [BUS-1:0] b_eff;
  logic           alu_arith;
  always_comb begin
    alu_sum   = '0;
    b_eff     = alu_b;
    alu_arith = 1'b1;
    case (alu_fun)
      ALU_ADD: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_ADC: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{BUS{1'b0}}, alu_cnvz_in[3]};
      ALU_SUB: begin
        b_eff   = ~alu_b;
        alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
      end
      ALU_SBC: begin
        b_eff   = ~alu_b;
        alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{BUS{1'b0}}, alu_cnvz_in[3]};
      end
      ALU_AND: begin alu_arith = 1'b0; alu_sum = {1'b0, alu_a & alu_b}; end
      ALU_XOR: begin alu_arith = 1'b0; alu_sum = {1'b0, alu_a ^ alu_b}; end
      default: alu_arith = 1'b0;
    endcase
    alu_s           = alu_sum[BUS-1:0];
    alu_cnvz_out[3] = alu_arith & alu_sum[BUS];
    alu_cnvz_out[2] = alu_sum[BUS-1];
    alu_cnvz_out[1] = alu_arith && (alu_a[BUS-1] == b_eff[BUS-1]) &&
                      (alu_sum[BUS-1] != alu_a[BUS-1]);
    alu_cnvz_out[0] = (alu_sum[BUS-1:0] == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: plain integer arithmetic on the full width.
  task automatic ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic [3:0] f);
    logic [W:0] full;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (o)
      2'd0: begin
        full = {1'b0, a} + {1'b0, b};
        r = full[W-1:0];
        c = full[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'd1: begin
        r = a - b;
        c = (a >= b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'd2:    r = a & b;
      default: r = a ^ b;
    endcase
    f = {c, r[W-1], v, (r == '0)};
  endtask

  // Borrow-free flag of the low k limbs of a - b.
  function automatic logic low_no_borrow(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input int k);
    logic [W-1:0] mask;
    mask = (W'(1) << (k * BUS)) - W'(1);
    return (a & mask) >= (b & mask);
  endfunction

  // One full operation. glitch: RUN cycle index at which a stray start is pulsed
  // (0 = none). seq: also check per-limb function/carry sequencing for SUB.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int glitch, input bit seq);
    logic [W-1:0] er;
    logic [3:0]   ef;
    int           cyc;
    bit           busy_ok;
    ref_op(o, a, b, er, ef);
    @(negedge clk);
    op = o; a_wide = a; b_wide = b; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc <= 3 * LIMBS) begin
      busy_ok &= busy;
      if (seq) begin
        check("seq_fun", 32'(alu_fun), (cyc == 1) ? 32'(ALU_SUB) : 32'(ALU_SBC));
        check("seq_cin", 32'(alu_cnvz_in[3]),
              (cyc == 1) ? 32'd0 : 32'(low_no_borrow(a, b, cyc - 1)));
      end
      op     = 2'($urandom_range(0, 3));
      a_wide = W'($urandom);
      b_wide = W'($urandom);
      start  = (cyc == glitch);
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(LIMBS + 1));
    check("busy_run", 32'(busy_ok), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("result", 32'(result), 32'(er));
    check("cnvz", 32'(cnvz), 32'(ef));
    // start coincident with done is ignored; done must drop after one cycle.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("held_result", 32'(result), 32'(er));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           seen_done;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cnvz", 32'(cnvz), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_fun", 32'(alu_fun), 32'(ALU_AND));
    check("rst_alu_cin", 32'(alu_cnvz_in), 32'd0);
    reset = 1'b0;

    run_op(2'd0, 16'h00FF, 16'h0001, 0, 1'b0);
    run_op(2'd0, 16'hFFFF, 16'h0001, 0, 1'b0);
    run_op(2'd0, 16'h7FFF, 16'h0001, 0, 1'b0);
    run_op(2'd1, 16'h0000, 16'h0001, 0, 1'b0);
    run_op(2'd1, 16'h1000, 16'h0001, 0, 1'b1);
    run_op(2'd3, 16'hF0F0, 16'hF0F0, 0, 1'b0);
    run_op(2'd2, 16'h8001, 16'hFFFF, 0, 1'b0);
    run_op(2'd0, 16'h1234, 16'h1111, 2, 1'b0);

    // Reset in the middle of an operation.
    @(negedge clk);
    op = 2'd0; a_wide = 16'h1234; b_wide = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_cnvz", 32'(cnvz), 32'd0);
    check("mid_rst_fun", 32'(alu_fun), 32'(ALU_AND));
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_done |= done;
    end
    check("mid_rst_no_done", 32'(seen_done), 32'd0);
    run_op(2'd0, 16'h1234, 16'h1111, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ra;
      run_op(2'($urandom_range(0, 3)), ra, rb, $urandom_range(0, LIMBS), 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      run_op(2'd1, W'($urandom), W'($urandom), 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
